// File: rtl/led_blink_multi.sv
// Multi-channel LED driver (OFF/ON/BLINK/BURST) sharing one prescaled time base.
// Config and tick effects are visible one cycle after the edge; no backpressure.
module led_blink_multi #(
  parameter int N_CH     = 4,
  parameter int PRESCALE = 50000,
  parameter int HALF_W   = 8,
  parameter int CNT_W    = 8,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [HALF_W-1:0] cfg_half,
  input  logic [CNT_W-1:0]  cfg_count,
  output logic [N_CH-1:0]   led,
  output logic [N_CH-1:0]   burst_done,
  output logic              tick
);

  localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_ON    = 2'b01,
    ST_BLINK = 2'b10,
    ST_BURST = 2'b11
  } state_t;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic              tick_q, tick_d;
  state_t            st_q   [N_CH];
  state_t            st_d   [N_CH];
  logic [HALF_W-1:0] half_q [N_CH];
  logic [HALF_W-1:0] half_d [N_CH];
  logic [HALF_W-1:0] hc_q   [N_CH];
  logic [HALF_W-1:0] hc_d   [N_CH];
  logic [CNT_W-1:0]  rem_q  [N_CH];
  logic [CNT_W-1:0]  rem_d  [N_CH];
  logic [N_CH-1:0]   led_q, led_d;
  logic [N_CH-1:0]   done_q, done_d;

  always_comb begin
    pc_d   = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;
    tick_d = (pc_d == PC_LAST);
    led_d  = led_q;
    done_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      st_d[i]   = st_q[i];
      half_d[i] = half_q[i];
      hc_d[i]   = hc_q[i];
      rem_d[i]  = rem_q[i];
      // A write to this channel takes precedence over a coincident tick.
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        half_d[i] = (cfg_half == '0) ? HALF_W'(1) : cfg_half;
        rem_d[i]  = cfg_count;
        hc_d[i]   = '0;
        case (cfg_mode)
          2'b00: begin st_d[i] = ST_OFF;   led_d[i] = 1'b0; end
          2'b01: begin st_d[i] = ST_ON;    led_d[i] = 1'b1; end
          2'b10: begin st_d[i] = ST_BLINK; led_d[i] = 1'b1; end
          default: begin
            if (cfg_count == '0) begin
              st_d[i]   = ST_OFF;
              led_d[i]  = 1'b0;
              done_d[i] = 1'b1;
            end else begin
              st_d[i]   = ST_BURST;
              led_d[i]  = 1'b1;
            end
          end
        endcase
      end else if (tick_q && (st_q[i] == ST_BLINK || st_q[i] == ST_BURST)) begin
        if (hc_q[i] == half_q[i] - 1'b1) begin
          hc_d[i]  = '0;
          led_d[i] = ~led_q[i];
          // Each falling edge of a burst consumes one flash.
          if (st_q[i] == ST_BURST && led_q[i]) begin
            rem_d[i] = rem_q[i] - 1'b1;
            if (rem_q[i] == CNT_W'(1)) begin
              st_d[i]   = ST_OFF;
              led_d[i]  = 1'b0;
              done_d[i] = 1'b1;
            end
          end
        end else begin
          hc_d[i] = hc_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      tick_q <= 1'b0;
      led_q  <= '0;
      done_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]   <= ST_OFF;
        half_q[i] <= HALF_W'(1);
        hc_q[i]   <= '0;
        rem_q[i]  <= '0;
      end
    end else begin
      pc_q   <= pc_d;
      tick_q <= tick_d;
      led_q  <= led_d;
      done_q <= done_d;
      for (int i = 0; i < N_CH; i++) begin
        st_q[i]   <= st_d[i];
        half_q[i] <= half_d[i];
        hc_q[i]   <= hc_d[i];
        rem_q[i]  <= rem_d[i];
      end
    end
  end

  assign led        = led_q;
  assign burst_done = done_q;
  assign tick       = tick_q;

endmodule

// File: tb/tb_led_blink_multi.sv
// Directed bench for led_blink_multi with PRESCALE=4; a second 3-channel
// instance exercises the out-of-range channel select.
module tb_led_blink_multi;

  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_ON    = 2'b01;
  localparam logic [1:0] M_BLINK = 2'b10;
  localparam logic [1:0] M_BURST = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we, cfg_we3;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_half;
  logic [3:0] cfg_count;
  logic [3:0] led, burst_done;
  logic       tick;
  logic [2:0] led3, burst_done3;
  logic       tick3;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_blink_multi #(.N_CH(4), .PRESCALE(4), .HALF_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_half(cfg_half), .cfg_count(cfg_count),
    .led(led), .burst_done(burst_done), .tick(tick)
  );

  led_blink_multi #(.N_CH(3), .PRESCALE(4), .HALF_W(4), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we3), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_half(cfg_half), .cfg_count(cfg_count),
    .led(led3), .burst_done(burst_done3), .tick(tick3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    chk("wait_tick", {31'b0, tick}, 32'd1);
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] mode,
                    input logic [3:0] half, input logic [3:0] cnt);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_half = half; cfg_count = cnt;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wr3(input logic [1:0] ch, input logic [1:0] mode);
    cfg_we3 = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_half = 4'd1; cfg_count = 4'd0;
    step();
    cfg_we3 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_we3 = 1'b0;
    cfg_ch = '0; cfg_mode = '0; cfg_half = '0; cfg_count = '0;

    // 1: reset state and prescaler phase after release
    step(3);
    rst = 1'b0;
    chk("rst_led", {28'b0, led}, 32'h0);
    chk("rst_done", {28'b0, burst_done}, 32'h0);
    chk("rst_tick", {31'b0, tick}, 32'h0);
    chk("rst_led3", {29'b0, led3}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t1_tick", {31'b0, tick}, {31'b0, (i % 4) == 2});
      chk("t1_led", {28'b0, led}, 32'h0);
    end

    // 2: ch0 BLINK half=2 written on a tick cycle -> 8 high, 8 low
    wait_tick();
    wr(2'd0, M_BLINK, 4'd2, 4'd0);
    for (int j = 0; j < 24; j++) begin
      chk("t2_led", {28'b0, led}, {31'b0, ((j / 8) % 2) == 0});
      step();
    end
    wr(2'd0, M_OFF, 4'd1, 4'd0);
    chk("t2_off", {28'b0, led}, 32'h0);

    // 3: ch1 BURST half=1 count=3 -> three 4-cycle flashes, done on last fall
    wait_tick();
    wr(2'd1, M_BURST, 4'd1, 4'd3);
    for (int j = 0; j < 32; j++) begin
      chk("t3_led", {28'b0, led}, {30'b0, (j < 20) && (((j / 4) % 2) == 0), 1'b0});
      chk("t3_done", {28'b0, burst_done}, {30'b0, j == 20, 1'b0});
      step();
    end

    // 4: ch2 ON written on a tick cycle stays static; out-of-range select ignored
    wait_tick();
    wr(2'd2, M_ON, 4'd3, 4'd0);
    for (int j = 0; j < 12; j++) begin
      chk("t4_led", {28'b0, led}, 32'h4);
      step();
    end
    wr3(2'd3, M_ON);
    for (int j = 0; j < 4; j++) begin
      chk("t4_oor_led3", {29'b0, led3}, 32'h0);
      step();
    end
    chk("t4_oor_led", {28'b0, led}, 32'h4);
    wr3(2'd2, M_ON);
    chk("t4_inr_led3", {29'b0, led3}, 32'h4);

    // 5: ch3 BURST count=0 -> immediate done, then BLINK half=0 acts as half=1
    wait_tick();
    wr(2'd3, M_BURST, 4'd1, 4'd0);
    chk("t5_zero_led", {28'b0, led}, 32'h4);
    chk("t5_zero_done", {28'b0, burst_done}, 32'h8);
    for (int j = 0; j < 4; j++) begin
      step();
      chk("t5_done_clr", {28'b0, burst_done}, 32'h0);
      chk("t5_led_hold", {28'b0, led}, 32'h4);
    end
    wait_tick();
    wr(2'd3, M_BLINK, 4'd0, 4'd0);
    for (int j = 0; j < 16; j++) begin
      chk("t5_blink", {28'b0, led}, {28'b0, ((j / 4) % 2) == 0, 3'b100});
      step();
    end

    // 6: reset in the middle of a burst flash
    wait_tick();
    wr(2'd1, M_BURST, 4'd1, 4'd5);
    chk("t6_start", {28'b0, led[1]}, 32'h1);
    step(2);
    rst = 1'b1;
    step();
    chk("t6_rst_led", {28'b0, led}, 32'h0);
    chk("t6_rst_done", {28'b0, burst_done}, 32'h0);
    chk("t6_rst_tick", {31'b0, tick}, 32'h0);
    step();
    chk("t6_rst_done2", {28'b0, burst_done}, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("t6_tick", {31'b0, tick}, {31'b0, (i % 4) == 2});
      chk("t6_led", {28'b0, led}, 32'h0);
      chk("t6_done", {28'b0, burst_done}, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
